// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two dmem requesters, the arbiter and the dmem macro.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
    parameter int AW = 13
);
    logic        i_p0_req;
    logic        i_p0_we;
    logic [3:0]  i_p0_wbe;
    logic [31:0] i_p0_addr;
    logic [31:0] i_p0_wdata;
    logic        o_p0_gnt;
    logic        o_p0_rvalid;
    logic [31:0] o_p0_rdata;
    logic        o_p0_err;

    logic        i_p1_req;
    logic        i_p1_we;
    logic [3:0]  i_p1_wbe;
    logic [31:0] i_p1_addr;
    logic [31:0] i_p1_wdata;
    logic        o_p1_gnt;
    logic        o_p1_rvalid;
    logic [31:0] o_p1_rdata;
    logic        o_p1_err;

    logic          o_mem_wen;
    logic [3:0]    o_mem_wbe;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [31:0]   i_mem_rdata;

    modport slave (
        input  i_p0_req, i_p0_we, i_p0_wbe, i_p0_addr, i_p0_wdata,
        output o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
        input  i_p1_req, i_p1_we, i_p1_wbe, i_p1_addr, i_p1_wdata,
        output o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
        output o_mem_wen, o_mem_wbe, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_p0_req, i_p0_we, i_p0_wbe, i_p0_addr, i_p0_wdata,
        input  o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
        output i_p1_req, i_p1_we, i_p1_wbe, i_p1_addr, i_p1_wdata,
        input  o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
        input  o_mem_wen, o_mem_wbe, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port dmem: core (p0) has fixed priority,
// the debug/loader port (p1) is forced through after STARVE_LIMIT denials.
module dmem_arbiter #(
    parameter int MEM_DEPTH    = 4096,
    parameter int AW           = 13,
    parameter int STARVE_LIMIT = 8
) (
    input logic           clk_sys,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);
    localparam logic [7:0]  LIMIT   = 8'(STARVE_LIMIT);

    // One-stage return pipeline: what was granted last cycle and where it goes.
    typedef struct packed {
        logic valid;
        logic port;
        logic err;
        logic is_read;
    } ret_t;

    logic [7:0]    starve_q, starve_d;
    ret_t          ret_q, ret_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic        p0_gnt, p1_gnt, any_gnt;
    logic        sel_we;
    logic [3:0]  sel_wbe;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_in_range;
    logic [1:0]  unused_addr_lsb;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (bus.i_p0_req && bus.i_p1_req) begin
                if (starve_q >= LIMIT) p1_gnt = 1'b1;
                else                   p0_gnt = 1'b1;
            end else begin
                p0_gnt = bus.i_p0_req;
                p1_gnt = bus.i_p1_req;
            end
        end
    end

    assign any_gnt   = p0_gnt | p1_gnt;
    assign sel_we    = p1_gnt ? bus.i_p1_we    : bus.i_p0_we;
    assign sel_wbe   = p1_gnt ? bus.i_p1_wbe   : bus.i_p0_wbe;
    assign sel_addr  = p1_gnt ? bus.i_p1_addr  : bus.i_p0_addr;
    assign sel_wdata = p1_gnt ? bus.i_p1_wdata : bus.i_p0_wdata;

    // Byte offset is irrelevant to a word-wide memory.
    assign sel_in_range    = sel_addr[31:2] < DEPTH_W;
    assign unused_addr_lsb = sel_addr[1:0];

    always_comb begin
        starve_d = 8'd0;
        if (bus.i_p1_req && !p1_gnt) begin
            starve_d = (starve_q >= LIMIT) ? starve_q : starve_q + 8'd1;
        end

        ret_d.valid   = any_gnt;
        ret_d.port    = p1_gnt;
        ret_d.err     = any_gnt & ~sel_in_range;
        ret_d.is_read = any_gnt & ~sel_we;

        // Address and write data only move on a grant to keep dmem inputs quiet.
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (rst) begin
            addr_d  = '0;
            wdata_d = '0;
        end else if (any_gnt) begin
            addr_d  = sel_addr[AW+1:2];
            wdata_d = sel_wdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
        if (rst) begin
            starve_q <= 8'd0;
            ret_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            starve_q <= starve_d;
            ret_q    <= ret_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    logic ret_hit0, ret_hit1;
    logic p0_rvalid, p1_rvalid;

    // Gating by rst drops a response whose grant preceded the reset edge.
    assign ret_hit0  = ret_q.valid & ~rst & ~ret_q.port;
    assign ret_hit1  = ret_q.valid & ~rst &  ret_q.port;
    assign p0_rvalid = ret_hit0 & ret_q.is_read;
    assign p1_rvalid = ret_hit1 & ret_q.is_read;

    assign bus.o_p0_gnt    = p0_gnt;
    assign bus.o_p0_rvalid = p0_rvalid;
    assign bus.o_p0_err    = ret_hit0 & ret_q.err;
    assign bus.o_p0_rdata  = (p0_rvalid && !ret_q.err) ? bus.i_mem_rdata : 32'd0;

    assign bus.o_p1_gnt    = p1_gnt;
    assign bus.o_p1_rvalid = p1_rvalid;
    assign bus.o_p1_err    = ret_hit1 & ret_q.err;
    assign bus.o_p1_rdata  = (p1_rvalid && !ret_q.err) ? bus.i_mem_rdata : 32'd0;

    assign bus.o_mem_wen   = any_gnt & sel_in_range & sel_we;
    assign bus.o_mem_wbe   = bus.o_mem_wen ? sel_wbe : 4'd0;
    assign bus.o_mem_addr  = addr_d;
    assign bus.o_mem_wdata = wdata_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares whenever a port returns rvalid/err.
module tb_dmem_arbiter;

    localparam int AW = 13;

    typedef struct packed {
        logic [3:0]  flags;   // {p0_rvalid, p0_err, p1_rvalid, p1_err}
        logic [31:0] rd0;
        logic [31:0] rd1;
    } resp_t;

    localparam resp_t NO_RESP = '0;

    logic  clk_sys;
    logic  rst;
    int    n_checks = 0;
    int    n_errors = 0;
    resp_t exp_q[$];
    logic [31:0] dmem [4096];

    dmem_arbiter_if #(.AW(AW)) bus ();

    dmem_arbiter #(
        .MEM_DEPTH   (4096),
        .AW          (AW),
        .STARVE_LIMIT(8)
    ) dut (
        .clk_sys(clk_sys),
        .rst    (rst),
        .bus    (bus)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // dmem contents: word w holds 0xC0DE0000 | w, except word 0x10.
    initial begin
        for (int w = 0; w < 4096; w++) dmem[w] <= 32'hC0DE_0000 | 32'(w);
        dmem[16] <= 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wbe,
                                          input logic [31:0] wdata);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wbe[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction

    // Synchronous single-port dmem, write-first.
    always @(posedge clk_sys) begin
        if (bus.o_mem_wen) begin
            dmem[bus.o_mem_addr] <= merge(dmem[bus.o_mem_addr], bus.o_mem_wbe, bus.o_mem_wdata);
            bus.i_mem_rdata      <= merge(dmem[bus.o_mem_addr], bus.o_mem_wbe, bus.o_mem_wdata);
        end else begin
            bus.i_mem_rdata <= dmem[bus.o_mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic resp_t mk_resp(input bit port, input bit rv, input bit er,
                                      input logic [31:0] rd);
        resp_t r;
        r.flags = port ? {2'b00, rv, er} : {rv, er, 2'b00};
        r.rd0   = port ? 32'd0 : rd;
        r.rd1   = port ? rd : 32'd0;
        return r;
    endfunction

    task automatic monitor_step();
        resp_t e;
        logic [3:0] flags;
        flags = {bus.o_p0_rvalid, bus.o_p0_err, bus.o_p1_rvalid, bus.o_p1_err};
        if (flags != 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got flags %b expected none", flags);
            end else begin
                e = exp_q.pop_front();
                check("resp_flags", 64'(flags), 64'(e.flags));
                check("resp_rdata", {bus.o_p0_rdata, bus.o_p1_rdata}, {e.rd0, e.rd1});
            end
        end
    endtask

    always @(negedge clk_sys) monitor_step();

    task automatic drive(input bit port, input logic req, input logic we, input logic [3:0] wbe,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.i_p1_req = req; bus.i_p1_we = we; bus.i_p1_wbe = wbe;
            bus.i_p1_addr = addr; bus.i_p1_wdata = wdata;
        end else begin
            bus.i_p0_req = req; bus.i_p0_we = we; bus.i_p0_wbe = wbe;
            bus.i_p0_addr = addr; bus.i_p0_wdata = wdata;
        end
    endtask

    // Sample at the negedge of the current cycle: grant check plus optional expectation.
    task automatic sample(input string name, input logic [1:0] exp_gnt, input bit push,
                          input resp_t resp);
        @(negedge clk_sys);
        check(name, 64'({bus.o_p0_gnt, bus.o_p1_gnt}), 64'(exp_gnt));
        if (push) exp_q.push_back(resp);
    endtask

    task automatic adv();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);

        // Reset held three cycles with both ports requesting.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            check("reset_outputs", 64'({bus.o_p0_gnt, bus.o_p1_gnt, bus.o_mem_wen, bus.o_mem_wbe,
                  bus.o_p0_rvalid, bus.o_p0_err, bus.o_p1_rvalid, bus.o_p1_err}), 64'd0);
            check("reset_rdata", {bus.o_p0_rdata, bus.o_p1_rdata}, 64'd0);
        end
        adv();
        rst = 1'b0;

        // First cycle after reset: p0 wins, single read of 0x40.
        sample("post_reset_gnt", 2'b10, 1'b1, mk_resp(0, 1, 0, 32'hDEAD_BEEF));
        check("single_rd_addr", 64'(bus.o_mem_addr), 64'(13'h010));
        adv();
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        sample("idle_gnt", 2'b00, 1'b0, NO_RESP);
        adv();

        // Starvation: continuous contention gives an 8:1 pattern.
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        for (int k = 0; k < 18; k++) begin
            if (k % 9 == 8) sample("starve_gnt", 2'b01, 1'b1, mk_resp(1, 1, 0, 32'hC0DE_00C0));
            else            sample("starve_gnt", 2'b10, 1'b1, mk_resp(0, 1, 0, 32'hC0DE_0080));
            adv();
        end
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        sample("starve_drain", 2'b00, 1'b0, NO_RESP);
        adv();

        // Back-to-back partial write then read of the same word.
        drive(0, 1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'h1234_5678);
        sample("b2b_wr_gnt", 2'b10, 1'b0, NO_RESP);
        check("b2b_wr_mem", 64'({bus.o_mem_wen, bus.o_mem_wbe, bus.o_mem_addr, bus.o_mem_wdata}),
              64'({1'b1, 4'b0011, 13'h040, 32'h1234_5678}));
        adv();
        drive(0, 1'b1, 1'b0, 4'b0000, 32'h0000_0100, 32'h1234_5678);
        sample("b2b_rd_gnt", 2'b10, 1'b1, mk_resp(0, 1, 0, 32'hC0DE_5678));
        check("b2b_rd_mem", 64'({bus.o_mem_wen, bus.o_mem_addr}), 64'({1'b0, 13'h040}));
        adv();

        // No grant: dmem address and data hold even though p0 inputs move.
        drive(0, 1'b0, 1'b1, 4'b1111, 32'h0000_0ABC, 32'hFFFF_FFFF);
        sample("hold_gnt", 2'b00, 1'b0, NO_RESP);
        check("hold_mem", 64'({bus.o_mem_wen, bus.o_mem_wbe, bus.o_mem_addr, bus.o_mem_wdata}),
              64'({1'b0, 4'b0000, 13'h040, 32'h1234_5678}));
        adv();

        // Out-of-range read and write on p1, then last in-range word.
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_4000, 32'h0);
        sample("oor_rd_gnt", 2'b01, 1'b1, mk_resp(1, 1, 1, 32'h0));
        check("oor_rd_wen", 64'(bus.o_mem_wen), 64'd0);
        adv();
        drive(1, 1'b1, 1'b1, 4'hF, 32'h0000_8000, 32'hBADB_AD00);
        sample("oor_wr_gnt", 2'b01, 1'b1, mk_resp(1, 0, 1, 32'h0));
        check("oor_wr_wen", 64'(bus.o_mem_wen), 64'd0);
        adv();
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_3FFC, 32'h0);
        sample("last_word_gnt", 2'b01, 1'b1, mk_resp(1, 1, 0, 32'hC0DE_0FFF));
        check("last_word_addr", 64'(bus.o_mem_addr), 64'(13'h0FFF));
        adv();
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
        sample("word0_gnt", 2'b10, 1'b1, mk_resp(0, 1, 0, 32'hC0DE_0000));
        adv();
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0);
        sample("oor_drain", 2'b00, 1'b0, NO_RESP);
        adv();

        // Reset one cycle after a p1 read grant: the response is dropped.
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        sample("mid_rd_gnt", 2'b01, 1'b0, NO_RESP);
        adv();
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b0;
            sample("mid_rst_gnt", 2'b00, 1'b0, NO_RESP);
            check("mid_rst_p1", 64'({bus.o_p1_rvalid, bus.o_p1_err, bus.o_p1_rdata}), 64'd0);
            adv();
        end

        // Counter built up to 6, then reset: a full 8 p0 grants must precede p1.
        drive(0, 1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0);
        for (int k = 0; k < 6; k++) begin
            sample("pre_rst_gnt", 2'b10, (k < 5), mk_resp(0, 1, 0, 32'hC0DE_0080));
            adv();
        end
        rst = 1'b1;
        sample("cnt_rst_gnt", 2'b00, 1'b0, NO_RESP);
        adv();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) sample("cnt_clr_gnt", 2'b01, 1'b1, mk_resp(1, 1, 0, 32'hC0DE_00C0));
            else        sample("cnt_clr_gnt", 2'b10, 1'b1, mk_resp(0, 1, 0, 32'hC0DE_0080));
            adv();
        end
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        sample("final_idle", 2'b00, 1'b0, NO_RESP);
        adv();
        sample("final_idle", 2'b00, 1'b0, NO_RESP);

        check("resp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
